// File: rtl/localmem_pkg.sv
// Shared constants, FSM state type and twiddle field helpers for the twiddle memory sequencer.
// TW_RE/TW_IM select the real/imag halves of a twiddle word.
`define TW_RE(w) w[TM_DATA_W-1:TM_DATA_W/2]
`define TW_IM(w) w[TM_DATA_W/2-1:0]

package localmem_pkg;

  localparam int TM_DATA_W     = 24;
  localparam int TM_BLOCK_ADDR = 4;
  localparam int TM_BLOCK_NUM  = 4;
  localparam int TM_LOG2N      = 7;
  localparam int TM_DEPTH      = TM_BLOCK_NUM << TM_BLOCK_ADDR;
  localparam int TM_SEL_W      = $clog2(TM_BLOCK_NUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } tmem_ctrl_state_t;

  // Conjugate: negate the imag field, clamping the most negative value to the most positive.
  function automatic logic [TM_DATA_W-1:0] tw_conj(input logic [TM_DATA_W-1:0] w);
    logic [TM_DATA_W/2-1:0] im;
    logic [TM_DATA_W/2-1:0] neg;
    im = `TW_IM(w);
    if (im == {1'b1, {(TM_DATA_W/2-1){1'b0}}}) begin
      neg = {1'b0, {(TM_DATA_W/2-1){1'b1}}};
    end else begin
      neg = ~im + {{(TM_DATA_W/2-1){1'b0}}, 1'b1};
    end
    return {`TW_RE(w), neg};
  endfunction

endpackage

// File: rtl/tmem_twaddr_gen.sv
// Per-stage twiddle address generator: read index counter j and address t = (j mod 2^s) << (LOG2N-1-s),
// split into block select and word address.
module tmem_twaddr_gen
  import localmem_pkg::*;
#(
  parameter int BLOCK_ADDR = TM_BLOCK_ADDR,
  parameter int BLOCK_NUM  = TM_BLOCK_NUM,
  parameter int LOG2N      = TM_LOG2N,
  parameter int STG_W      = $clog2(LOG2N),
  parameter int SEL_W      = $clog2(BLOCK_NUM)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_step,
  input  logic [STG_W-1:0]      i_stage,
  output logic                  o_last,
  output logic [SEL_W-1:0]      o_blk,
  output logic [BLOCK_ADDR-1:0] o_addr
);

  localparam int D  = BLOCK_NUM << BLOCK_ADDR;
  localparam int AW = $clog2(D);

  logic [AW-1:0]    r_j;
  logic [STG_W-1:0] w_shift;
  logic [AW-1:0]    w_mask;
  logic [AW-1:0]    w_t;

  // Read index counter, one step per issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_j <= '0;
    end else if (i_clr) begin
      r_j <= '0;
    end else if (i_step) begin
      r_j <= r_j + AW'(1);
    end else begin
      r_j <= r_j;
    end
  end

  // AW equals LOG2N-1, so the same shift both sizes the mask and scales the address.
  always_comb begin
    w_shift = STG_W'(LOG2N - 1) - i_stage;
    w_mask  = {AW{1'b1}} >> w_shift;
    w_t     = (r_j & w_mask) << w_shift;
    o_blk   = w_t[AW-1:BLOCK_ADDR];
    o_addr  = w_t[BLOCK_ADDR-1:0];
    o_last  = (r_j == AW'(D - 1));
  end

endmodule

// File: rtl/tmem_ctrl.sv
// Twiddle memory sequencer: host load on port 1, per-stage twiddle read stream on port 2.
// Optional TMEM_CTRL_CONJ_EN adds an 'inv' input that conjugates the read stream.
module tmem_ctrl
  import localmem_pkg::*;
#(
  parameter int DATA_W     = TM_DATA_W,
  parameter int BLOCK_ADDR = TM_BLOCK_ADDR,
  parameter int BLOCK_NUM  = TM_BLOCK_NUM,
  parameter int LOG2N      = TM_LOG2N
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_valid,
  input  logic [DATA_W-1:0]             ld_data,
  output logic                          ld_ready,
  input  logic                          start,
  input  logic [$clog2(LOG2N)-1:0]      stage,
`ifdef TMEM_CTRL_CONJ_EN
  input  logic                          inv,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          tw_valid,
  output logic [DATA_W-1:0]             tw_data,
  output logic                          WEB1,
  output logic                          OEB1,
  output logic [BLOCK_NUM-1:0]          CSB1,
  output logic [BLOCK_ADDR-1:0]         A1,
  output logic [DATA_W-1:0]             I1,
  output logic                          WEB2,
  output logic                          OEB2,
  output logic [BLOCK_NUM-1:0]          CSB2,
  output logic [BLOCK_ADDR-1:0]         A2,
  input  logic [BLOCK_NUM*DATA_W-1:0]   O2
);

  localparam int D     = BLOCK_NUM << BLOCK_ADDR;
  localparam int AW    = $clog2(D);
  localparam int SEL_W = $clog2(BLOCK_NUM);
  localparam int STG_W = $clog2(LOG2N);

  tmem_ctrl_state_t r_state;
  tmem_ctrl_state_t w_next;

  logic [AW-1:0]         r_wa;
  logic                  r_drain;
  logic [STG_W-1:0]      r_stage;
  logic                  r_iss_d;
  logic [SEL_W-1:0]      r_sel_d;
  logic                  r_tw_valid;
  logic [DATA_W-1:0]     r_tw_data;
  logic                  r_done;
  logic                  r_inv;

  logic                  w_ld_acc;
  logic                  w_issue;
  logic                  w_start_rd;
  logic                  w_last;
  logic [STG_W-1:0]      w_stage_c;
  logic [SEL_W-1:0]      w_blk;
  logic [BLOCK_ADDR-1:0] w_addr;
  logic [DATA_W-1:0]     w_slice;
  logic [DATA_W-1:0]     w_word;
  logic                  w_inv_in;

`ifdef TMEM_CTRL_CONJ_EN
  assign w_inv_in = inv;
`else
  assign w_inv_in = 1'b0;
`endif

  tmem_twaddr_gen #(
    .BLOCK_ADDR (BLOCK_ADDR),
    .BLOCK_NUM  (BLOCK_NUM),
    .LOG2N      (LOG2N),
    .STG_W      (STG_W),
    .SEL_W      (SEL_W)
  ) u_twaddr (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start_rd),
    .i_step  (w_issue),
    .i_stage (r_stage),
    .o_last  (w_last),
    .o_blk   (w_blk),
    .o_addr  (w_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start wins over a load request arriving in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_READ;
        end else if (ld_valid) begin
          w_next = ST_LOAD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_ld_acc && (r_wa == AW'(D - 1))) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_LOAD;
        end
      end
      ST_READ: begin
        if (w_last) begin
          w_next = ST_DRAIN;
        end else begin
          w_next = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (r_drain) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_DRAIN;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Output decode and macro controls; port-1 controls follow the accept in the same cycle.
  always_comb begin
    ld_ready   = (r_state == ST_LOAD);
    busy       = (r_state != ST_IDLE);
    w_ld_acc   = (r_state == ST_LOAD) && ld_valid;
    w_issue    = (r_state == ST_READ);
    w_start_rd = (r_state == ST_IDLE) && start;
    w_stage_c  = (stage >= STG_W'(LOG2N)) ? STG_W'(LOG2N - 1) : stage;
    WEB1 = 1'b1;
    OEB1 = 1'b1;
    CSB1 = {BLOCK_NUM{1'b1}};
    A1   = '0;
    I1   = '0;
    WEB2 = 1'b1;
    OEB2 = 1'b1;
    CSB2 = {BLOCK_NUM{1'b1}};
    A2   = '0;
    if (w_ld_acc) begin
      WEB1 = 1'b0;
      CSB1[r_wa[AW-1:BLOCK_ADDR]] = 1'b0;
      A1   = r_wa[BLOCK_ADDR-1:0];
      I1   = ld_data;
    end else begin
      WEB1 = 1'b1;
    end
    if (w_issue) begin
      OEB2 = 1'b0;
      CSB2[w_blk] = 1'b0;
      A2   = w_addr;
    end else begin
      OEB2 = 1'b1;
    end
  end

  // Stage and conjugate mode are captured only when a read sequence is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
      r_inv   <= 1'b0;
    end else if (w_start_rd) begin
      r_stage <= w_stage_c;
      r_inv   <= w_inv_in;
    end else begin
      r_stage <= r_stage;
      r_inv   <= r_inv;
    end
  end

  // Load write address and drain cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wa    <= '0;
      r_drain <= 1'b0;
    end else begin
      if (w_ld_acc) begin
        r_wa <= r_wa + AW'(1);
      end else if (r_state == ST_IDLE) begin
        r_wa <= '0;
      end else begin
        r_wa <= r_wa;
      end
      r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
    end
  end

  always_comb begin
    w_slice = O2[int'(r_sel_d)*DATA_W +: DATA_W];
    if (r_inv) begin
      w_word = tw_conj(w_slice);
    end else begin
      w_word = w_slice;
    end
  end

  // Read pipeline: block select travels with the read, data registered one cycle after the macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_d    <= 1'b0;
      r_sel_d    <= '0;
      r_tw_valid <= 1'b0;
      r_tw_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_iss_d    <= w_issue;
      r_sel_d    <= w_blk;
      r_tw_valid <= r_iss_d;
      r_tw_data  <= r_iss_d ? w_word : r_tw_data;
      r_done     <= (w_ld_acc && (r_wa == AW'(D - 1))) ||
                    ((r_state == ST_DRAIN) && !r_drain);
    end
  end

  assign tw_valid = r_tw_valid;
  assign tw_data  = r_tw_data;
  assign done     = r_done;

endmodule
